// File: rtl/mux_sel_arbiter.sv
// ---------------------------------------------------------------------------
// mux_sel_arbiter
//   Control stage ahead of a 2:1 mux. It arbitrates between two requesters,
//   holds each grant for a programmable minimum dwell, and inserts a one-cycle
//   break-before-make gap on every grant release, so the mux select only ever
//   moves while no grant is active.
//
// Ports
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   req0/req1  : requester 0 wants mux input I0, requester 1 wants I1
//   dwell      : grant dwell length in cycles, sampled at grant start (0 -> 1)
//   s0         : registered mux select (0 = I0, 1 = I1)
//   gnt0/gnt1  : registered one-hot grants
//   busy       : high whenever the arbiter is not idle
//   switch_cnt : saturating count of s0 transitions since reset
// ---------------------------------------------------------------------------
module mux_sel_arbiter #(
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic [DWELL_W-1:0] dwell,
  output logic               s0,
  output logic               gnt0,
  output logic               gnt1,
  output logic               busy,
  output logic [CNT_W-1:0]   switch_cnt
);

  typedef enum logic [1:0] {IDLE, HOLD0, HOLD1, GAP} state_e;

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic               last_q, last_d;
  logic               s0_q, s0_d;
  logic               gnt0_q, gnt1_q, busy_q;
  logic [CNT_W-1:0]   sw_q, sw_d;

  logic               pick_vld;
  logic               pick;
  logic               own;
  logic               req_own;
  logic               req_oth;

  // A zero dwell still grants for one cycle.
  function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    last_d   = last_q;
    s0_d     = s0_q;
    pick_vld = 1'b0;
    pick     = 1'b0;
    own      = (state_q == HOLD1);
    req_own  = own ? req1 : req0;
    req_oth  = own ? req0 : req1;

    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          pick_vld = 1'b1;
          pick     = ~last_q;
        end else if (req0 || req1) begin
          pick_vld = 1'b1;
          pick     = req1;
        end
      end
      HOLD0, HOLD1: begin
        // Owner dropping out releases at once; otherwise the other side only
        // gets a look-in when the dwell window expires.
        if (!req_own) begin
          state_d = GAP;
        end else if (dcnt_q == DWELL_W'(1)) begin
          if (req_oth) state_d = GAP;
          else         dcnt_d  = dwell_load(dwell);
        end else begin
          dcnt_d = dcnt_q - DWELL_W'(1);
        end
      end
      GAP: begin
        // last_q still names the channel that was just released.
        if (last_q ? req0 : req1) begin
          pick_vld = 1'b1;
          pick     = ~last_q;
        end else if (last_q ? req1 : req0) begin
          pick_vld = 1'b1;
          pick     = last_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every grant start, from IDLE or GAP, loads the same way; s0 moves only here.
    if (pick_vld) begin
      state_d = pick ? HOLD1 : HOLD0;
      dcnt_d  = dwell_load(dwell);
      last_d  = pick;
      s0_d    = pick;
    end

    sw_d = (s0_d != s0_q) ? sat_inc(sw_q) : sw_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
      last_q  <= 1'b1;
      s0_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      sw_q    <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      last_q  <= last_d;
      s0_q    <= s0_d;
      gnt0_q  <= (state_d == HOLD0);
      gnt1_q  <= (state_d == HOLD1);
      busy_q  <= (state_d != IDLE);
      sw_q    <= sw_d;
    end
  end

  assign s0         = s0_q;
  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign busy       = busy_q;
  assign switch_cnt = sw_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_sel_arbiter
//   Directed vector table covering reset, single-request hold, alternation,
//   early release, zero dwell and reset mid-grant, then a saturation burst
//   and a randomized run checked against a behavioural model. The switch
//   counter is narrowed to 4 bits so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_mux_sel_arbiter;

  localparam int DWELL_W = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk;
  logic               rst;
  logic               req0, req1;
  logic [DWELL_W-1:0] dwell;
  logic               s0, gnt0, gnt1, busy;
  logic [CNT_W-1:0]   switch_cnt;

  mux_sel_arbiter #(.DWELL_W(DWELL_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .dwell      (dwell),
    .s0         (s0),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .busy       (busy),
    .switch_cnt (switch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- behavioural reference model ----------------
  // mode: 0 idle, 1 serving owner, 2 one-cycle gap after owner
  int m_mode  = 0;
  int m_owner = 0;
  int m_left  = 0;
  int m_last  = 1;
  int m_s0    = 0;
  int m_sw    = 0;
  int m_next;
  int m_dw;

  always @(posedge clk) begin
    m_dw   = (int'(dwell) == 0) ? 1 : int'(dwell);
    m_next = -1;
    if (rst) begin
      m_mode = 0; m_left = 0; m_last = 1; m_s0 = 0; m_sw = 0;
    end else begin
      if (m_mode == 0) begin
        if (req0 && req1)  m_next = 1 - m_last;
        else if (req0)     m_next = 0;
        else if (req1)     m_next = 1;
      end else if (m_mode == 1) begin
        if (!((m_owner == 1) ? req1 : req0))      m_mode = 2;
        else if (m_left == 1) begin
          if ((m_owner == 1) ? req0 : req1)       m_mode = 2;
          else                                    m_left = m_dw;
        end else                                  m_left = m_left - 1;
      end else begin
        if ((m_owner == 1) ? req0 : req1)         m_next = 1 - m_owner;
        else if ((m_owner == 1) ? req1 : req0)    m_next = m_owner;
        else                                      m_mode = 0;
      end
      if (m_next >= 0) begin
        m_mode = 1; m_owner = m_next; m_left = m_dw; m_last = m_next;
        if (m_next != m_s0 && m_sw < CNT_MAX) m_sw = m_sw + 1;
        m_s0 = m_next;
      end
    end
  end

  // ---------------- comparison helper ----------------
  task automatic check(input string name, input int idx,
                       input bit es0, input bit eg0, input bit eg1,
                       input bit eb, input int ecnt);
    n_vec++;
    if (s0 !== es0 || gnt0 !== eg0 || gnt1 !== eg1 || busy !== eb ||
        switch_cnt !== CNT_W'(ecnt)) begin
      n_bad++;
      $display("FAIL %s[%0d]: got s0=%b gnt0=%b gnt1=%b busy=%b cnt=%0d, want s0=%b gnt0=%b gnt1=%b busy=%b cnt=%0d",
               name, idx, s0, gnt0, gnt1, busy, switch_cnt, es0, eg0, eg1, eb, ecnt);
    end
  endtask

  task automatic check_model(input string name, input int idx);
    check(name, idx, m_s0[0], (m_mode == 1 && m_owner == 0),
          (m_mode == 1 && m_owner == 1), (m_mode != 0), m_sw);
  endtask

  task automatic drive(input bit r, input bit a, input bit b, input int dw);
    rst = r; req0 = a; req1 = b; dwell = DWELL_W'(dw);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst, r0, r1;
    int dw;
    bit s0, g0, g1, busy;
    int cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit a, input bit b, input int dw,
                     input bit es0, input bit eg0, input bit eg1, input bit eb,
                     input int ecnt);
    vec_t v;
    v.rst = r; v.r0 = a; v.r1 = b; v.dw = dw;
    v.s0 = es0; v.g0 = eg0; v.g1 = eg1; v.busy = eb; v.cnt = ecnt;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; dwell = '0;

    //   rst r0 r1 dw   s0 g0 g1 busy cnt
    // reset and idle
    add(1, 0, 0, 0,   0, 0, 0, 0, 0);
    add(1, 0, 0, 0,   0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0,   0, 0, 0, 0, 0);
    // single request held: granted indefinitely through reloads
    for (int i = 0; i < 8; i++) add(0, 1, 0, 4,   0, 1, 0, 1, 0);
    add(0, 0, 0, 4,   0, 0, 0, 1, 0);
    add(0, 0, 0, 4,   0, 0, 0, 0, 0);
    // fresh reset, then alternation with dwell 3
    add(1, 0, 0, 3,   0, 0, 0, 0, 0);
    add(0, 1, 1, 3,   0, 1, 0, 1, 0);
    add(0, 1, 1, 3,   0, 1, 0, 1, 0);
    add(0, 1, 1, 3,   0, 1, 0, 1, 0);
    add(0, 1, 1, 3,   0, 0, 0, 1, 0);
    add(0, 1, 1, 3,   1, 0, 1, 1, 1);
    add(0, 1, 1, 3,   1, 0, 1, 1, 1);
    add(0, 1, 1, 3,   1, 0, 1, 1, 1);
    add(0, 1, 1, 3,   1, 0, 0, 1, 1);
    add(0, 1, 1, 3,   0, 1, 0, 1, 2);
    // early release: owner drops mid-dwell, then req1 only
    add(0, 0, 1, 10,  0, 0, 0, 1, 2);
    add(0, 0, 1, 10,  1, 0, 1, 1, 3);
    add(0, 0, 1, 10,  1, 0, 1, 1, 3);
    add(0, 0, 0, 10,  1, 0, 0, 1, 3);
    add(0, 0, 0, 10,  1, 0, 0, 0, 3);
    // dwell zero: one-cycle grants separated by one gap
    add(0, 1, 1, 0,   0, 1, 0, 1, 4);
    add(0, 1, 1, 0,   0, 0, 0, 1, 4);
    add(0, 1, 1, 0,   1, 0, 1, 1, 5);
    add(0, 1, 1, 0,   1, 0, 0, 1, 5);
    add(0, 1, 1, 0,   0, 1, 0, 1, 6);
    add(0, 1, 1, 0,   0, 0, 0, 1, 6);
    // reset during HOLD1 with dwell 5 loaded; channel 0 wins afterwards
    add(0, 1, 1, 5,   1, 0, 1, 1, 7);
    add(1, 1, 1, 5,   0, 0, 0, 0, 0);
    add(0, 1, 1, 5,   0, 1, 0, 1, 0);

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].r0, tbl[i].r1, tbl[i].dw);
      check("table", i, tbl[i].s0, tbl[i].g0, tbl[i].g1, tbl[i].busy, tbl[i].cnt);
    end

    // ---------------- saturation burst ----------------
    drive(1, 0, 0, 0);
    check("sat_reset", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      drive(0, 1, 1, 0);
      check_model("sat", i);
    end
    check("sat_final", 0, m_s0[0], (m_mode == 1 && m_owner == 0),
          (m_mode == 1 && m_owner == 1), 1'b1, CNT_MAX);

    // ---------------- randomized run vs model ----------------
    drive(1, 0, 0, 0);
    check_model("rnd_reset", 0);
    begin
      bit a, b;
      int dw;
      a = 1'b0; b = 1'b0; dw = 2;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 5) == 0) a = ~a;
        if ($urandom_range(0, 5) == 0) b = ~b;
        if ($urandom_range(0, 15) == 0) dw = $urandom_range(0, 6);
        drive(($urandom_range(0, 299) == 0), a, b, dw);
        check_model("rnd", i);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
